// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction sequencer.
package vend_pkg;

    localparam int unsigned CREDIT_W_DEF = 8;

    typedef enum logic [1:0] {
        StIdle,
        StCheck,
        StDispense,
        StChange
    } state_e;

    localparam logic [2:0] CODE_1 = 3'd1;
    localparam logic [2:0] CODE_2 = 3'd2;
    localparam logic [2:0] CODE_3 = 3'd3;
    localparam logic [2:0] CODE_4 = 3'd4;
    localparam logic [2:0] CODE_5 = 3'd5;
    localparam logic [2:0] CODE_6 = 3'd6;

    localparam int unsigned PRICE_1 = 110;
    localparam int unsigned PRICE_2 = 150;
    localparam int unsigned PRICE_3 = 190;
    localparam int unsigned PRICE_4 = 230;
    localparam int unsigned PRICE_5 = 243;
    localparam int unsigned PRICE_6 = 30;

    function automatic logic is_valid_code(input logic [2:0] code);
        return (code != 3'd0) && (code != 3'd7);
    endfunction

endpackage

// File: rtl/vend_price_rom.sv
// Combinational product-code to price lookup; valid is low for codes 0 and 7.
module vend_price_rom
    import vend_pkg::*;
#(
    parameter int unsigned CREDIT_W = CREDIT_W_DEF
) (
    input  logic [2:0]          code,
    output logic [CREDIT_W-1:0] price,
    output logic                valid
);

    always_comb begin
        price = '0;
        valid = is_valid_code(code);
        case (code)
            CODE_1:  price = CREDIT_W'(PRICE_1);
            CODE_2:  price = CREDIT_W'(PRICE_2);
            CODE_3:  price = CREDIT_W'(PRICE_3);
            CODE_4:  price = CREDIT_W'(PRICE_4);
            CODE_5:  price = CREDIT_W'(PRICE_5);
            CODE_6:  price = CREDIT_W'(PRICE_6);
            default: price = '0;
        endcase
    end

endmodule

// File: rtl/vend_txn_ctrl.sv
// Vending transaction sequencer: credit accumulation, price check, dispense and change handshakes.
// Optional idle auto-refund is enabled by defining VEND_IDLE_TIMEOUT_EN.
module vend_txn_ctrl
    import vend_pkg::*;
#(
    parameter int unsigned CREDIT_W    = CREDIT_W_DEF,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_valid,
    input  logic [CREDIT_W-1:0] coin_value,
    output logic                coin_reject,
    input  logic                sel_valid,
    input  logic [2:0]          sel_type,
    input  logic                cancel,
    output logic [CREDIT_W-1:0] credit,
    output logic                disp_valid,
    output logic [2:0]          disp_type,
    input  logic                disp_ready,
    output logic                chg_valid,
    output logic [CREDIT_W-1:0] chg_amt,
    input  logic                chg_ready,
    output logic                sold,
    output logic                short_err
);

    if (TIMEOUT_CYC == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be nonzero");
    end

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [2:0]          sel_q, sel_d;
    logic                disp_valid_q, disp_valid_d;
    logic [2:0]          disp_type_q, disp_type_d;
    logic                chg_valid_q, chg_valid_d;
    logic [CREDIT_W-1:0] chg_amt_q, chg_amt_d;
    logic                sold_q, sold_d;
    logic                short_err_q, short_err_d;
    logic                coin_reject_q, coin_reject_d;

    logic [CREDIT_W-1:0] price;
    logic                price_valid;
    logic [CREDIT_W:0]   coin_sum;
    logic [CREDIT_W-1:0] credit_idle;
    logic                timeout_hit;

    vend_price_rom #(
        .CREDIT_W (CREDIT_W)
    ) u_price_rom (
        .code  (sel_q),
        .price (price),
        .valid (price_valid)
    );

`ifdef VEND_IDLE_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] idle_cnt_q;
    logic             idle_quiet;

    assign idle_quiet  = (state_q == StIdle) && (credit_q != '0) && !coin_valid && !sel_valid;
    assign timeout_hit = idle_quiet && (idle_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || !idle_quiet || timeout_hit) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign coin_sum = {1'b0, credit_q} + {1'b0, coin_value};

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        sel_d         = sel_q;
        disp_valid_d  = disp_valid_q;
        disp_type_d   = disp_type_q;
        chg_valid_d   = chg_valid_q;
        chg_amt_d     = chg_amt_q;
        sold_d        = 1'b0;
        short_err_d   = 1'b0;
        coin_reject_d = 1'b0;
        credit_idle   = credit_q;

        unique case (state_q)
            StIdle: begin
                // Coin is folded in first so a same-cycle selection sees the new credit.
                if (coin_valid) begin
                    if (coin_sum[CREDIT_W]) begin
                        coin_reject_d = 1'b1;
                    end else begin
                        credit_idle = coin_sum[CREDIT_W-1:0];
                    end
                end
                credit_d = credit_idle;
                if ((cancel || timeout_hit) && (credit_idle != '0)) begin
                    chg_valid_d = 1'b1;
                    chg_amt_d   = credit_idle;
                    state_d     = StChange;
                end else if (sel_valid) begin
                    sel_d   = sel_type;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (price_valid && (credit_q >= price)) begin
                    credit_d     = credit_q - price;
                    disp_valid_d = 1'b1;
                    disp_type_d  = sel_q;
                    state_d      = StDispense;
                end else begin
                    short_err_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            StDispense: begin
                if (disp_ready) begin
                    disp_valid_d = 1'b0;
                    disp_type_d  = 3'd0;
                    sold_d       = 1'b1;
                    if (credit_q != '0) begin
                        chg_valid_d = 1'b1;
                        chg_amt_d   = credit_q;
                        state_d     = StChange;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StChange: begin
                if (chg_ready) begin
                    chg_valid_d = 1'b0;
                    chg_amt_d   = '0;
                    credit_d    = '0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if ((state_q != StIdle) && coin_valid) begin
            coin_reject_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            credit_q      <= '0;
            sel_q         <= 3'd0;
            disp_valid_q  <= 1'b0;
            disp_type_q   <= 3'd0;
            chg_valid_q   <= 1'b0;
            chg_amt_q     <= '0;
            sold_q        <= 1'b0;
            short_err_q   <= 1'b0;
            coin_reject_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            sel_q         <= sel_d;
            disp_valid_q  <= disp_valid_d;
            disp_type_q   <= disp_type_d;
            chg_valid_q   <= chg_valid_d;
            chg_amt_q     <= chg_amt_d;
            sold_q        <= sold_d;
            short_err_q   <= short_err_d;
            coin_reject_q <= coin_reject_d;
        end
    end

    assign credit      = credit_q;
    assign disp_valid  = disp_valid_q;
    assign disp_type   = disp_type_q;
    assign chg_valid   = chg_valid_q;
    assign chg_amt     = chg_amt_q;
    assign sold        = sold_q;
    assign short_err   = short_err_q;
    assign coin_reject = coin_reject_q;

endmodule

// File: doc/vend_txn_ctrl.md
Name: vend_txn_ctrl

Overview:
- Transaction sequencer for the vending datapath. Accumulates inserted credit and accepts a product selection, then compares credit against the price table.
- On success it issues a dispense handshake, then a change-return handshake; on shortfall it holds credit until more coins arrive, a new selection is made, or the user cancels.
- Sits between the coin/keypad front end and the dispense/change actuators. Its credit and change outputs feed the existing binary-to-seven-segment display path.

Parameters:
- CREDIT_W, 8, width of credit/change/price values (unsigned).
- TIMEOUT_CYC, 1000, idle cycles with nonzero credit before auto-refund (used only with the optional feature).

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- coin_valid  input  1  one-cycle strobe: coin_value is valid.
- coin_value  input  CREDIT_W  value of inserted coin.
- coin_reject  output  1  one-cycle pulse: coin refused (overflow or not accepting).
- sel_valid  input  1  one-cycle strobe: sel_type is valid.
- sel_type  input  3  product code 1..6; 0 and 7 are invalid.
- cancel  input  1  level/strobe: refund all credit.
- credit  output  CREDIT_W  current accumulated credit.
- disp_valid  output  1  dispense request, held until disp_ready.
- disp_type  output  3  product being dispensed; 0 when disp_valid=0.
- disp_ready  input  1  actuator accepts dispense.
- chg_valid  output  1  change-return request, held until chg_ready.
- chg_amt  output  CREDIT_W  change amount; 0 when chg_valid=0.
- chg_ready  input  1  change actuator accepts.
- sold  output  1  one-cycle pulse when a dispense handshake completes.
- short_err  output  1  one-cycle pulse: selection rejected for insufficient credit or invalid code.

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE. credit, chg_amt, disp_type = 0. disp_valid, chg_valid, sold, short_err, coin_reject = 0. Reset mid-handshake aborts it; credit is lost.
- States: IDLE, CHECK, DISPENSE, CHANGE.
- IDLE, coin_valid:
  - If credit+coin_value > 2^CREDIT_W-1: coin_reject pulses next cycle and credit is unchanged (no wrap).
  - Otherwise credit updates next cycle.
- IDLE, sel_valid: latch sel_type, go to CHECK. coin_valid in the same cycle is processed first, so the new credit is used in CHECK.
- IDLE, cancel with credit>0: chg_amt=credit, go to CHANGE. With credit=0, cancel is ignored. cancel has priority over sel_valid.
- CHECK (1 cycle), compare credit against price(sel):
  - If valid code and credit>=price: credit <= credit-price, go to DISPENSE.
  - Otherwise short_err pulses, return to IDLE, credit unchanged.
  - Selection-to-disp_valid latency is 2 cycles.
- DISPENSE:
  - disp_valid=1, disp_type=latched code, stable until disp_ready.
  - On the disp_ready cycle: sold pulses next cycle. If credit>0, chg_amt=credit and go to CHANGE; else credit stays 0 and go to IDLE.
- CHANGE:
  - chg_valid=1, chg_amt stable until chg_ready.
  - On chg_ready: credit=0, chg_amt=0, go to IDLE.
- Busy behaviour: in CHECK, DISPENSE and CHANGE, coin_valid produces coin_reject and sel_valid/cancel are ignored.
- Price table: code 1=110, 2=150, 3=190, 4=230, 5=243, 6=30; 0 and 7 invalid.
- All outputs are registered.

Optional Feature:
- Macro VEND_IDLE_TIMEOUT_EN.
- Defined:
  - Counter increments each cycle in IDLE with credit>0 and no coin_valid/sel_valid; it resets on either strobe.
  - On reaching TIMEOUT_CYC it behaves as cancel (go to CHANGE with full credit).
  - Counter clears on reset and on leaving IDLE.
- Undefined: no counter is instantiated; credit is held indefinitely.

Decomposition:
- Package vend_pkg:
  - state enum.
  - product code constants.
  - price constants.
  - CREDIT_W default.
  - function is_valid_code.
- Sub-module vend_price_rom: combinational code-to-price lookup with a valid flag. The controller instantiates it once.

Test Plan:
- Coins 100, 50; select 2 -> credit 150 then 0; disp_valid with type 2 two cycles after sel_valid; sold pulses; no change phase.
- Coins 200, 50; select 1; disp_ready after 3 cycles -> disp_type 1 held 3 cycles; chg_valid with chg_amt 140; chg_ready -> credit 0, IDLE.
- Credit 100, select 1 -> short_err, credit stays 100; add coin 10, select 1 -> dispense, no change.
- Credit 250, coin 10 -> coin_reject, credit 250. Select 7 -> short_err. Cancel -> chg_amt 250.
- Assert rst_n=0 while disp_valid=1 -> next cycle all outputs 0, state IDLE. With VEND_IDLE_TIMEOUT_EN and TIMEOUT_CYC=20, credit 30 idle 20 cycles -> chg_valid with chg_amt 30.
